rob_commit_arbiter: RTL and testbench
=====================================

# rob_commit_arbiter

Shares the single ROB commit write port between the reservation stations (integer, branch, memory, mul/div). Each cycle it picks one station with a pending commit (round-robin by default) and returns a one-hot grant that the station uses as its `rob_commit_en`, invalidating the committed line. It latches the winner's result into a one-entry output register that drives the ROB with a valid/ready handshake. It sits between the RS array and the ROB commit write logic.

## Interface
- `NUM_RS`, default 4: number of requesting reservation stations, legal range 2..8.
- `SRC_W`, default 2: width of the source index; must equal clog2(`NUM_RS`).
- `clk` in, 1: clock; all state updates on the rising edge.
- `rst` in, 1: reset; asynchronous, active-low.
- `flush` in, 1: pipeline flush on exception or mispredict.
- `req` in, `NUM_RS`: per-station `can_commit`.
- `req_rob_addr` in, `NUM_RS` × `ROB_ADDR_BUS`: packed `rob_commit_addr`, station 0 in the LSBs.
- `req_exc_type` in, `NUM_RS` × `EXC_TYPE_BUS`: packed `rob_commit_exc_type`.
- `req_data` in, `NUM_RS` × `DATA_BUS`: packed `rob_commit_data`.
- `grant` out, `NUM_RS`: one-hot or zero; drives each station's `rob_commit_en`.
- `rob_valid` out, 1: output register holds a commit for the ROB.
- `rob_ready` in, 1: the ROB accepts the commit this cycle.
- `rob_addr` out, `ROB_ADDR_BUS`: ROB entry being completed.
- `rob_exc_type` out, `EXC_TYPE_BUS`: exception type of the entry.
- `rob_data` out, `DATA_BUS`: result data.
- `rob_src` out, `SRC_W`: index of the station that produced the entry.

## Operation
- **Slot free:** `slot_free = !rob_valid || rob_ready`.
- **Grant condition:** `grant` is combinational and is nonzero only when all three hold:
  - `slot_free`
  - `!flush`
  - `|req`
- **Winner selection:** the first requester at or after `rr_ptr`, searching cyclically through indices 0..`NUM_RS`-1.
- **Single grant:** at most one `grant` bit is set per cycle. The granting edge invalidates that station's line, so the chosen request is consumed exactly once.
- **On a grant edge:**
  - Output register loads the winner's addr, exc_type and data; `rob_src` gets the winner index; `rob_valid` goes to 1.
  - `rr_ptr` gets winner+1, wrapping from `NUM_RS`-1 to 0.
- **Consume without refill:** if `rob_valid && rob_ready` and there is no grant, `rob_valid` goes to 0 and the data fields hold their last value.
- **Flush:**
  - `rob_valid` goes to 0 on the next edge and `grant` is 0 during the flush cycle.
  - An entry already presented is still transferred if `rob_ready` is high in the flush cycle; the ROB is responsible for discarding it.
  - `rr_ptr` is unchanged.
- **Request masking:** requests are not held or registered inside the block. A station that drops `req` without a grant is simply not considered.
- **Starvation bound:** with the round-robin feature enabled, a continuously requesting station is granted within `NUM_RS` grant cycles.

## Timing
- Request to `grant`: 0 cycles, combinational. Request to `rob_valid`: 1 cycle.
- Throughput: one commit per cycle while `rob_ready` stays high.
- A stall (`rob_valid=1`, `rob_ready=0`) holds the output register stable and keeps `grant=0`.
- Reset values: `rob_valid=0`, `rob_addr=0`, `rob_exc_type=0`, `rob_data=0`, `rob_src=0`, `rr_ptr=0`. `grant` is 0 while `rst` is low.
- Reset asserted mid-stall: the presented entry is dropped immediately, asynchronously.
- Simultaneous `flush` and a full `req` vector: no grant, and all requests stay pending.

## Configuration
- `COMMIT_ARB_RR_EN`:
  - **Defined:** round-robin selection as described above, with the `rr_ptr` register.
  - **Undefined:** fixed priority, lowest index wins. The `rr_ptr` logic is not synthesised and `rob_src` still reports the winner.

## Structure
- Shared headers:
  - Bus widths `ROB_ADDR_BUS`, `EXC_TYPE_BUS` and `DATA_BUS` come from the existing `bus.v`/`rob.v`.
  - A new `arb.v` holds the default `COMMIT_ARB_NUM_RS` constant and the `COMMIT_ARB_RR_EN` default.
- One sub-module, `rr_pick`: a parameterised combinational picker.
  - Inputs: `req` vector and `rr_ptr`.
  - Outputs: one-hot `grant` and the binary winner index.
  - Implementation: double-width rotate with first-one detect.
  - It is reused later for CDB arbitration.

## Test plan
- **Reset then single request:** `rst` low, then high; `req=4'b0100`, addr 5, data `0xDEAD` → `grant=4'b0100` in the same cycle; next cycle `rob_valid=1`, `rob_addr=5`, `rob_data=0xDEAD`, `rob_src=2`.
- **Round-robin fairness:** `req=4'b1111` held with `rob_ready=1` for 8 cycles → grants in order 0,1,2,3,0,1,2,3, one per cycle. With the macro undefined, every grant goes to station 0.
- **Backpressure:** `rob_ready=0` with an entry valid and `req=4'b0011` for 3 cycles → `grant=0` and outputs stable. When `rob_ready` rises, the next grant goes to station 1 (pointer was 1 after the station-0 win).
- **Flush:** `flush=1` with `req=4'b1000` and the slot empty → no grant and `rob_valid` stays 0. The cycle after flush drops, station 3 is granted.
- **Async reset mid-stall:** `rob_valid=1`, `rob_ready=0`, then `rst` pulsed low between edges → `rob_valid` goes to 0 immediately with no clock edge, and `rr_ptr` returns to 0.
- **Wrap-around:** `rr_ptr=3`, `req=4'b1001` → station 3 is granted and the pointer wraps to 0. Next cycle station 0 is granted.

Source files
------------

// File: rtl/rob_commit_arbiter_pkg.sv
// Shared constants for the ROB commit arbiter: bus widths, default station
// count and the output register entry layout.
// Optional feature macro: COMMIT_ARB_RR_EN. Define it to get round-robin
// selection. Leave it undefined to get fixed priority, where the lowest index wins.
package rob_commit_arbiter_pkg;

    localparam int ROB_ADDR_BUS      = 6;
    localparam int EXC_TYPE_BUS      = 4;
    localparam int DATA_BUS          = 32;

    localparam int COMMIT_ARB_NUM_RS = 4;
    localparam int COMMIT_ARB_SRC_W  = 2;

    typedef struct packed {
        logic [ROB_ADDR_BUS-1:0] addr;
        logic [EXC_TYPE_BUS-1:0] exc_type;
        logic [DATA_BUS-1:0]     data;
    } commit_entry_t;

endpackage

// File: rtl/rob_commit_arbiter_rr_pick.sv
// Parameterised combinational round-robin picker. It rotates the request vector
// so that i_ptr lands at bit 0 and finds the first set bit. It then maps that
// offset back to an absolute index. The result is a one-hot grant plus the
// binary winner index. The same picker is intended for CDB arbitration.
module rob_commit_arbiter_rr_pick #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] i_req,
    input  logic [W-1:0] i_ptr,
    output logic [N-1:0] o_grant,
    output logic [W-1:0] o_idx
);

    logic [N-1:0] w_rot;
    logic [W-1:0] w_off;
    logic [W:0]   w_sum;

    // Rotate requests by the pointer, take the first one, and un-rotate the index modulo N.
    always_comb begin
        w_rot = N'({i_req, i_req} >> i_ptr);
        w_off = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_off = W'(i);
            end
        end
        w_sum = {1'b0, i_ptr} + {1'b0, w_off};
        if (w_sum >= (W+1)'(N)) begin
            w_sum = w_sum - (W+1)'(N);
        end
        o_idx   = w_sum[W-1:0];
        o_grant = (|i_req) ? (N'(1) << w_sum[W-1:0]) : '0;
    end

endmodule

// File: rtl/rob_commit_arbiter.sv
// ROB commit arbiter. It shares the single ROB commit write port between the
// reservation stations. The grant is combinational and one-hot. The winner's
// result is captured into a one-entry output register. That register drives the
// ROB through a valid/ready handshake.
// Optional feature macro: COMMIT_ARB_RR_EN. When it is defined, selection is
// round-robin using an rr_ptr register. When it is undefined, the pointer is
// tied to 0 and the lowest index wins.
//
// Handshake: the register holds a commit while rob_valid=1. A transfer happens
// on an edge where rob_valid && rob_ready. The slot may be refilled on that same
// edge. While rob_valid=1 and rob_ready=0, the register is frozen and grant=0.
module rob_commit_arbiter
    import rob_commit_arbiter_pkg::*;
#(
    parameter int NUM_RS = COMMIT_ARB_NUM_RS,
    parameter int SRC_W  = COMMIT_ARB_SRC_W
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           flush,
    input  logic [NUM_RS-1:0]              req,
    input  logic [NUM_RS*ROB_ADDR_BUS-1:0] req_rob_addr,
    input  logic [NUM_RS*EXC_TYPE_BUS-1:0] req_exc_type,
    input  logic [NUM_RS*DATA_BUS-1:0]     req_data,
    output logic [NUM_RS-1:0]              grant,
    output logic                           rob_valid,
    input  logic                           rob_ready,
    output logic [ROB_ADDR_BUS-1:0]        rob_addr,
    output logic [EXC_TYPE_BUS-1:0]        rob_exc_type,
    output logic [DATA_BUS-1:0]            rob_data,
    output logic [SRC_W-1:0]               rob_src
);

    logic                r_valid;
    commit_entry_t       r_entry;
    logic [SRC_W-1:0]    r_src;

    logic                w_slot_free;
    logic                w_grant_en;
    logic [SRC_W-1:0]    w_ptr;
    logic [NUM_RS-1:0]   w_pick_grant;
    logic [SRC_W-1:0]    w_win;
    commit_entry_t       w_sel;

    rob_commit_arbiter_rr_pick #(
        .N (NUM_RS),
        .W (SRC_W)
    ) u_pick (
        .i_req   (req),
        .i_ptr   (w_ptr),
        .o_grant (w_pick_grant),
        .o_idx   (w_win)
    );

`ifdef COMMIT_ARB_RR_EN
    logic [SRC_W-1:0] r_rr_ptr;

    // Advance the pointer past the winner on every grant, wrapping at NUM_RS-1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rr_ptr <= '0;
        end else if (w_grant_en) begin
            r_rr_ptr <= (w_win == SRC_W'(NUM_RS - 1)) ? '0 : w_win + 1'b1;
        end
    end

    assign w_ptr = r_rr_ptr;
`else
    assign w_ptr = '0;
`endif

    // Grant only into a free slot, outside flush and reset, and only when some station asks.
    always_comb begin
        w_slot_free = !r_valid || rob_ready;
        w_grant_en  = rst && w_slot_free && !flush && (|req);
        grant       = w_grant_en ? w_pick_grant : '0;
    end

    // Extract the winning station's commit fields from the packed request buses.
    always_comb begin
        w_sel.addr     = req_rob_addr[int'(w_win)*ROB_ADDR_BUS +: ROB_ADDR_BUS];
        w_sel.exc_type = req_exc_type[int'(w_win)*EXC_TYPE_BUS +: EXC_TYPE_BUS];
        w_sel.data     = req_data[int'(w_win)*DATA_BUS +: DATA_BUS];
    end

    // Output register: load on grant, drop on consume or flush, hold while stalled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid <= 1'b0;
            r_entry <= '0;
            r_src   <= '0;
        end else if (w_grant_en) begin
            r_valid <= 1'b1;
            r_entry <= w_sel;
            r_src   <= w_win;
        end else if (flush || rob_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign rob_valid    = r_valid;
    assign rob_addr     = r_entry.addr;
    assign rob_exc_type = r_entry.exc_type;
    assign rob_data     = r_entry.data;
    assign rob_src      = r_src;

endmodule

// File: tb/tb_rob_commit_arbiter.sv
// Directed bench for rob_commit_arbiter. It covers reset, a single request,
// fairness, backpressure, flush, wrap-around and async reset mid-stall.
// Expected values depend on whether COMMIT_ARB_RR_EN is defined.
module tb_rob_commit_arbiter;
    import rob_commit_arbiter_pkg::*;

    localparam int N  = 4;
    localparam int SW = 2;
`ifdef COMMIT_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic                      clk = 1'b0;
    logic                      rst;
    logic                      flush;
    logic [N-1:0]              req;
    logic [N*ROB_ADDR_BUS-1:0] req_rob_addr;
    logic [N*EXC_TYPE_BUS-1:0] req_exc_type;
    logic [N*DATA_BUS-1:0]     req_data;
    logic [N-1:0]              grant;
    logic                      rob_valid;
    logic                      rob_ready;
    logic [ROB_ADDR_BUS-1:0]   rob_addr;
    logic [EXC_TYPE_BUS-1:0]   rob_exc_type;
    logic [DATA_BUS-1:0]       rob_data;
    logic [SW-1:0]             rob_src;

    int n_cmp  = 0;
    int n_fail = 0;

    rob_commit_arbiter #(.NUM_RS(N), .SRC_W(SW)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .req          (req),
        .req_rob_addr (req_rob_addr),
        .req_exc_type (req_exc_type),
        .req_data     (req_data),
        .grant        (grant),
        .rob_valid    (rob_valid),
        .rob_ready    (rob_ready),
        .rob_addr     (rob_addr),
        .rob_exc_type (rob_exc_type),
        .rob_data     (rob_data),
        .rob_src      (rob_src)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_rs(input int i, input logic [ROB_ADDR_BUS-1:0] a,
                          input logic [EXC_TYPE_BUS-1:0] e, input logic [DATA_BUS-1:0] d);
        req_rob_addr[i*ROB_ADDR_BUS +: ROB_ADDR_BUS] = a;
        req_exc_type[i*EXC_TYPE_BUS +: EXC_TYPE_BUS] = e;
        req_data[i*DATA_BUS +: DATA_BUS]             = d;
    endtask

    initial begin
        int exp_w;
        int last_w;
        logic [DATA_BUS-1:0] exp_d;

        rst          = 1'b0;
        flush        = 1'b0;
        req          = '0;
        req_rob_addr = '0;
        req_exc_type = '0;
        req_data     = '0;
        rob_ready    = 1'b0;

        // Reset state, with a full request vector present during reset.
        req = 4'b1111;
        @(negedge clk);
        @(negedge clk);
        chk("reset_valid", 64'(rob_valid), 64'd0);
        chk("reset_addr", 64'(rob_addr), 64'd0);
        chk("reset_exc", 64'(rob_exc_type), 64'd0);
        chk("reset_data", 64'(rob_data), 64'd0);
        chk("reset_src", 64'(rob_src), 64'd0);
        chk("reset_grant", 64'(grant), 64'd0);
        req = '0;
        rst = 1'b1;
        @(negedge clk);

        // Single request from station 2.
        rob_ready = 1'b1;
        set_rs(2, 6'd5, 4'd3, 32'hDEAD);
        req = 4'b0100;
        #1;
        chk("single_grant", 64'(grant), 64'b0100);
        @(negedge clk);
        req = '0;
        chk("single_valid", 64'(rob_valid), 64'd1);
        chk("single_addr", 64'(rob_addr), 64'd5);
        chk("single_exc", 64'(rob_exc_type), 64'd3);
        chk("single_data", 64'(rob_data), 64'hDEAD);
        chk("single_src", 64'(rob_src), 64'd2);
        @(negedge clk);
        chk("consume_valid", 64'(rob_valid), 64'd0);
        chk("consume_hold_addr", 64'(rob_addr), 64'd5);

        // Fairness: the pointer sits at 3 after the station-2 win.
        for (int i = 0; i < N; i++) begin
            set_rs(i, 6'(8 + i), 4'(i), 32'h100 + 32'(i));
        end
        req = 4'b1111;
        last_w = 0;
        for (int k = 0; k < 10; k++) begin
            exp_w = RR ? (3 + k) % 4 : 0;
            #1;
            chk($sformatf("fair_grant_%0d", k), 64'(grant), 64'(4'b0001 << exp_w));
            @(negedge clk);
            chk($sformatf("fair_src_%0d", k), 64'(rob_src), 64'(exp_w));
            chk($sformatf("fair_data_%0d", k), 64'(rob_data), 64'(32'h100 + 32'(exp_w)));
            last_w = exp_w;
        end

        // Backpressure: the last winner was station 0, so the pointer is 1.
        rob_ready = 1'b0;
        req = 4'b0011;
        exp_d = 32'h100 + 32'(last_w);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("stall_grant_%0d", k), 64'(grant), 64'd0);
            @(negedge clk);
            chk($sformatf("stall_valid_%0d", k), 64'(rob_valid), 64'd1);
            chk($sformatf("stall_data_%0d", k), 64'(rob_data), 64'(exp_d));
            chk($sformatf("stall_src_%0d", k), 64'(rob_src), 64'(last_w));
        end
        rob_ready = 1'b1;
        #1;
        chk("unstall_grant", 64'(grant), RR ? 64'b0010 : 64'b0001);
        @(negedge clk);
        chk("unstall_src", 64'(rob_src), RR ? 64'd1 : 64'd0);
        req = '0;
        @(negedge clk);
        chk("drain_valid", 64'(rob_valid), 64'd0);

        // Flush with the slot empty and a request from station 3.
        flush = 1'b1;
        req = 4'b1000;
        #1;
        chk("flush_grant", 64'(grant), 64'd0);
        @(negedge clk);
        chk("flush_valid", 64'(rob_valid), 64'd0);
        flush = 1'b0;
        #1;
        chk("postflush_grant", 64'(grant), 64'b1000);
        @(negedge clk);
        chk("postflush_valid", 64'(rob_valid), 64'd1);
        chk("postflush_src", 64'(rob_src), 64'd3);

        // Flush during a stall with all stations requesting.
        rob_ready = 1'b0;
        flush = 1'b1;
        req = 4'b1111;
        #1;
        chk("flushfull_grant", 64'(grant), 64'd0);
        @(negedge clk);
        chk("flushfull_valid", 64'(rob_valid), 64'd0);
        flush = 1'b0;
        rob_ready = 1'b1;
        #1;
        chk("afterflush_grant", 64'(grant), 64'b0001);
        @(negedge clk);
        chk("afterflush_src", 64'(rob_src), 64'd0);

        // Wrap-around: a station-2 win moves the pointer to 3.
        req = 4'b0100;
        @(negedge clk);
        chk("wrap_setup_src", 64'(rob_src), 64'd2);
        req = 4'b1001;
        #1;
        chk("wrap_grant3", 64'(grant), RR ? 64'b1000 : 64'b0001);
        @(negedge clk);
        chk("wrap_src3", 64'(rob_src), RR ? 64'd3 : 64'd0);
        #1;
        chk("wrap_grant0", 64'(grant), 64'b0001);
        @(negedge clk);
        chk("wrap_src0", 64'(rob_src), 64'd0);

        // Async reset mid-stall: the entry is dropped with no clock edge.
        req = 4'b0010;
        @(negedge clk);
        req = '0;
        rob_ready = 1'b0;
        #1;
        chk("prereset_valid", 64'(rob_valid), 64'd1);
        #1;
        rst = 1'b0;
        #1;
        chk("async_valid", 64'(rob_valid), 64'd0);
        chk("async_data", 64'(rob_data), 64'd0);
        chk("async_src", 64'(rob_src), 64'd0);
        rst = 1'b1;
        rob_ready = 1'b1;
        req = 4'b1111;
        #1;
        chk("async_ptr_grant", 64'(grant), 64'b0001);
        @(negedge clk);
        chk("async_ptr_src", 64'(rob_src), 64'd0);
        req = '0;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
